multi_timer: RTL and testbench
==============================

# multi_timer

Multi-channel programmable down-counting timer; the successor to the single-channel cycle timer. Provides NUM_CH independent channels, each loaded with a cycle count. Each channel counts down to zero and pulses its `elapsed` output, running in one-shot or periodic mode. It sits beside control logic that needs timeouts, watchdogs or periodic strobes. Down-counting gives a zero-detect comparator, with no wide equality compare against a stored limit.

## Interface
- `NUM_CH`, 4, number of independent channels (≥1).
- `WIDTH`, 16, bit width of each channel's cycle count (≥1).
- `PRESCALE`, 8, clocks per count tick; used only when `MULTI_TIMER_PRESCALE_EN` is defined (≥1).

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  NUM_CH  per-channel load/start strobe.
- `cycles`  in  NUM_CH*WIDTH  per-channel count, channel i at bits [i*WIDTH +: WIDTH]; sampled on load.
- `periodic`  in  NUM_CH  mode, sampled on load: 1 = periodic, 0 = one-shot.
- `stop`  in  NUM_CH  per-channel stop strobe.
- `elapsed`  out  NUM_CH  one-clock pulse per expiry.
- `active`  out  NUM_CH  channel is in RUN.
- `count`  out  NUM_CH*WIDTH  current down-counter value per channel.

## Operation
- Per-channel state machine has two states: IDLE and RUN.
- Channels are fully independent; all share only clk, rst_n and the prescaler.
- Load, in any state:
  - `cycles_r` <= cycles[i], `count` <= cycles[i], `mode_r` <= periodic[i].
  - State goes to RUN.
  - An in-flight count is discarded, so a load in RUN restarts the channel.
- RUN on a count tick:
  - If `count` != 0: `count` <= `count` - 1.
  - If `count` == 0: `elapsed` <= 1.
  - At zero in periodic mode: `count` <= `cycles_r`, stay in RUN.
  - At zero in one-shot mode: go to IDLE, `count` stays 0.
- Stop: go to IDLE, `count` holds its value, no `elapsed` pulse.
- Per-channel priority: load > stop > tick. When stop and zero coincide, no `elapsed` is produced. When load and zero coincide, no `elapsed` is produced and the reload value comes from the new `cycles`.
- IDLE: `count` holds; `elapsed` stays 0.
- Counter arithmetic is WIDTH bits, unsigned. The counter never wraps, because zero is detected before decrement.
- cycles = 0 in periodic mode: `elapsed` is high on every tick.
- cycles = 2^WIDTH-1 is legal.

## Timing
- Reset (rst_n low, asynchronous) drives every output to 0: `elapsed`, `active` and `count`. `cycles_r` and `mode_r` also clear to 0, and all channels go to IDLE. Release is synchronous to clk.
- `elapsed` and `active` are registered outputs.
- `active` goes high the clock after the load edge.
- Without prescaler, with load sampled at edge E0:
  - `elapsed` is high for exactly one clock, following edge E(cycles+1).
  - Periodic period is cycles+1 clocks.
  - In one-shot mode, `active` drops in the same cycle `elapsed` is high.
- Stop sampled at edge E: `active` is low after E.
- Back-to-back load on consecutive clocks: the last one wins.

## Configuration
- `MULTI_TIMER_PRESCALE_EN` defined:
  - A shared free-running prescaler counts 0..PRESCALE-1 and resets to 0 on rst_n.
  - A tick occurs in the clock when the prescaler equals PRESCALE-1.
  - `count` decrements and zero-detects only on ticks.
  - Load and stop act immediately, not on ticks.
  - The first expiry after load arrives between cycles*PRESCALE+1 and (cycles+1)*PRESCALE clocks after the load edge.
  - The steady periodic period is (cycles+1)*PRESCALE clocks.
  - `elapsed` is still exactly one clock wide.
- Macro undefined: every clock is a tick, `PRESCALE` is ignored, and no prescaler logic is present.

## Test plan
- Reset mid-count: load ch0 cycles=10, assert rst_n low at clock 5 → all outputs are 0 immediately; after release no `elapsed` occurs.
- One-shot: ch1 load cycles=5, periodic=0 → `elapsed[1]` high for one clock, 6 clocks after the load edge; `active[1]` drops with it; no further pulses within 50 clocks.
- Periodic plus boundary: ch2 cycles=3, periodic=1 → pulses every 4 clocks; ch3 cycles=0, periodic=1 → `elapsed[3]` high on every clock after the load edge.
- Priority: ch0 periodic cycles=4, assert stop at the zero clock → no pulse, `active` goes to 0. Reload, then assert load with cycles=7 at the zero clock → no pulse; next pulse 8 clocks later.
- Independence plus max value: all channels loaded with different counts in the same clock, and WIDTH=4 with cycles=15 → each channel pulses at its own cycles+1, and the counter does not wrap.
- Prescaler, with `MULTI_TIMER_PRESCALE_EN` and PRESCALE=4: periodic cycles=2 → after the first expiry, pulses are 12 clocks apart, each one clock wide.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel programmable down-counting timer with one-shot and periodic modes.
// Define MULTI_TIMER_PRESCALE_EN to advance the counters only on shared prescaler ticks.
`timescale 1ns/1ps
module multi_timer #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] cycles,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       stop,
  output logic [NUM_CH-1:0]       elapsed,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH*WIDTH-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic tick;

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // Free-running prescaler shared by every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cycles_q, cycles_d;
    logic             mode_q, mode_d;
    logic             elapsed_q, elapsed_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        count_q   <= '0;
        cycles_q  <= '0;
        mode_q    <= 1'b0;
        elapsed_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        count_q   <= count_d;
        cycles_q  <= cycles_d;
        mode_q    <= mode_d;
        elapsed_q <= elapsed_d;
      end
    end

    // Load beats stop beats tick; zero is tested before decrementing so the counter never wraps.
    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      cycles_d  = cycles_q;
      mode_d    = mode_q;
      elapsed_d = 1'b0;
      if (load[i]) begin
        cycles_d = cycles[i*WIDTH +: WIDTH];
        count_d  = cycles[i*WIDTH +: WIDTH];
        mode_d   = periodic[i];
        state_d  = RUN;
      end else if (stop[i]) begin
        state_d = IDLE;
      end else if (state_q == RUN && tick) begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          elapsed_d = 1'b1;
          if (mode_q) begin
            count_d = cycles_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end

    assign elapsed[i]                = elapsed_q;
    assign active[i]                 = (state_q == RUN);
    assign count[i*WIDTH +: WIDTH]   = count_q;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: an elapsed-time model checked every cycle plus directed literal checks.
// With MULTI_TIMER_PRESCALE_EN defined only the prescaler spacing checks run.
`timescale 1ns/1ps
module tb_multi_timer;
  localparam int NUM_CH   = 4;
  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       load = '0;
  logic [NUM_CH*WIDTH-1:0] cycles = '0;
  logic [NUM_CH-1:0]       periodic = '0;
  logic [NUM_CH-1:0]       stop = '0;
  logic [NUM_CH-1:0]       elapsed;
  logic [NUM_CH-1:0]       active;
  logic [NUM_CH*WIDTH-1:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_timer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .cycles(cycles), .periodic(periodic),
    .stop(stop), .elapsed(elapsed), .active(active), .count(count)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge; inputs are sampled at the next posedge (E0); returns at the negedge after E0.
  task automatic apply_stimulus(input logic [NUM_CH-1:0] ld, input logic [NUM_CH-1:0] stp,
                                input logic [NUM_CH-1:0] per, input logic [NUM_CH*WIDTH-1:0] cyc);
    load = ld; stop = stp; periodic = per; cycles = cyc;
    @(negedge clk);
    load = '0; stop = '0;
  endtask

`ifndef MULTI_TIMER_PRESCALE_EN
  // Model: outputs follow from edges elapsed since the last load, the loaded count and the mode.
  int                edge_k = 0;
  bit                m_run [NUM_CH];
  int                m_l   [NUM_CH];
  int                m_c   [NUM_CH];
  bit                m_per [NUM_CH];
  logic [NUM_CH-1:0] exp_el = '0;
  logic [NUM_CH-1:0] exp_act = '0;
  int                exp_cnt [NUM_CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 1'b0; exp_cnt[i] = 0;
      end
      exp_el = '0; exp_act = '0;
    end else begin
      edge_k++;
      for (int i = 0; i < NUM_CH; i++) begin
        int p;
        int q;
        exp_el[i] = 1'b0;
        if (load[i]) begin
          m_run[i] = 1'b1; m_l[i] = edge_k;
          m_c[i] = int'(cycles[i*WIDTH +: WIDTH]); m_per[i] = periodic[i];
        end else if (stop[i]) begin
          m_run[i] = 1'b0;
        end
        if (m_run[i]) begin
          p = edge_k - m_l[i];
          if (m_per[i]) begin
            q = p % (m_c[i] + 1);
            exp_el[i]  = (p > 0) && (q == 0);
            exp_cnt[i] = (q == 0) ? m_c[i] : m_c[i] - q;
          end else if (p == m_c[i] + 1) begin
            exp_el[i] = 1'b1; exp_cnt[i] = 0; m_run[i] = 1'b0;
          end else begin
            exp_cnt[i] = m_c[i] - p;
          end
        end
        exp_act[i] = m_run[i];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        check_output($sformatf("model_elapsed[%0d]", i), 32'(elapsed[i]), 32'(exp_el[i]));
        check_output($sformatf("model_active[%0d]", i), 32'(active[i]), 32'(exp_act[i]));
        check_output($sformatf("model_count[%0d]", i), 32'(count[i*WIDTH +: WIDTH]), 32'(exp_cnt[i]));
      end
    end
  end
`endif

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_elapsed", 32'(elapsed), 0);
    check_output("reset_active", 32'(active), 0);
    check_output("reset_count", 32'(count), 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifndef MULTI_TIMER_PRESCALE_EN
    // Reset in the middle of a count.
    apply_stimulus(4'b0001, 4'b0000, 4'b0000, 16'd10);
    repeat (4) @(negedge clk);
    check_output("midcount_count0", 32'(count[3:0]), 6);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_elapsed", 32'(elapsed), 0);
    check_output("async_reset_active", 32'(active), 0);
    check_output("async_reset_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_output("post_reset_active", 32'(active), 0);

    // One-shot channel 1, cycles = 5.
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, {4'd0, 4'd0, 4'd5, 4'd0});
    repeat (5) @(negedge clk);
    check_output("oneshot_before", 32'(elapsed[1]), 0);
    @(negedge clk);
    check_output("oneshot_pulse", 32'(elapsed[1]), 1);
    check_output("oneshot_active_drop", 32'(active[1]), 0);
    @(negedge clk);
    check_output("oneshot_width", 32'(elapsed[1]), 0);
    repeat (50) @(negedge clk);
    check_output("oneshot_idle_count", 32'(count[7:4]), 0);

    // Periodic channel 2 (cycles=3) and channel 3 (cycles=0).
    apply_stimulus(4'b1100, 4'b0000, 4'b1100, {4'd0, 4'd3, 4'd0, 4'd0});
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check_output($sformatf("periodic3_j%0d", j), 32'(elapsed[2]), 32'((j % 4) == 0));
      check_output($sformatf("periodic0_j%0d", j), 32'(elapsed[3]), 1);
    end
    apply_stimulus(4'b0000, 4'b1100, 4'b0000, '0);
    check_output("stop_active", 32'(active), 0);

    // Stop coinciding with zero, then load coinciding with zero.
    apply_stimulus(4'b0001, 4'b0000, 4'b0001, 16'd4);
    repeat (4) @(negedge clk);
    check_output("prio_at_zero", 32'(count[3:0]), 0);
    apply_stimulus(4'b0000, 4'b0001, 4'b0000, '0);
    check_output("prio_stop_no_pulse", 32'(elapsed[0]), 0);
    check_output("prio_stop_inactive", 32'(active[0]), 0);
    apply_stimulus(4'b0001, 4'b0000, 4'b0001, 16'd4);
    repeat (4) @(negedge clk);
    apply_stimulus(4'b0001, 4'b0000, 4'b0001, 16'd7);
    check_output("prio_load_no_pulse", 32'(elapsed[0]), 0);
    check_output("prio_load_count", 32'(count[3:0]), 7);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check_output($sformatf("prio_reload_j%0d", j), 32'(elapsed[0]), 32'(j == 8));
    end
    apply_stimulus(4'b0000, 4'b0001, 4'b0000, '0);

    // All channels loaded together, including the maximum count.
    apply_stimulus(4'b1111, 4'b0000, 4'b0000, {4'd15, 4'd6, 4'd2, 4'd9});
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      check_output($sformatf("indep_j%0d", j), 32'(elapsed),
                   32'({j == 16, j == 7, j == 3, j == 10}));
    end
    check_output("indep_no_wrap", 32'(count), 0);
    check_output("indep_idle", 32'(active), 0);

    // Back-to-back loads: the second one wins.
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, {4'd0, 4'd0, 4'd9, 4'd0});
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, {4'd0, 4'd0, 4'd3, 4'd0});
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check_output($sformatf("b2b_j%0d", j), 32'(elapsed[1]), 32'(j == 4));
    end
    repeat (12) @(negedge clk);
`else
    begin
      int n;
      apply_stimulus(4'b0100, 4'b0000, 4'b0100, {4'd0, 4'd2, 4'd0, 4'd0});
      n = 0;
      while (!elapsed[2] && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_output("pre_first_found", 32'(elapsed[2]), 1);
      check_output("pre_first_in_range", 32'((n >= 9) && (n <= 12)), 1);
      for (int r = 0; r < 3; r++) begin
        int gap;
        @(negedge clk);
        gap = 1;
        check_output($sformatf("pre_width_r%0d", r), 32'(elapsed[2]), 0);
        while (!elapsed[2] && gap < 100) begin
          @(negedge clk);
          gap++;
        end
        check_output($sformatf("pre_period_r%0d", r), 32'(gap), 12);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
